four_mem_result_reader: RTL and testbench

//  System-side burst reader for the four-bank result memory. On start, it issues LEN sequential

---
 rtl/four_mem_result_reader.sv | 154 +++++++++++++++
 tb/tb_four_mem_result_reader.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/four_mem_result_reader.sv
// rtl/four_mem_result_reader.sv - burst reader for the four-bank result memory with credit-limited output FIFO
// Optional FOUR_MEM_RD_STRIDE_EN adds a stride_i port; otherwise the address step is 1.
module four_mem_result_reader #(
  parameter int ADDR_WIDTH = 14,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start_i,
  input  logic                  abort_i,
  input  logic [ADDR_WIDTH-1:0] base_addr_i,
  input  logic [ADDR_WIDTH:0]   len_i,
`ifdef FOUR_MEM_RD_STRIDE_EN
  input  logic [ADDR_WIDTH-1:0] stride_i,
`endif
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH-1:0] sys_addr_o,
  output logic                  sys_cen_sel_o,
  output logic                  sys_wen_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i,
  output logic [DATA_WIDTH-1:0] m_data_o,
  output logic                  m_valid_o,
  input  logic                  m_ready_i,
  output logic                  m_last_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN} state_t;

  state_t                state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [ADDR_WIDTH:0]   rem_q;
  logic                  sys_last_q;
  logic                  inflight_q;
  logic                  inflight_last_q;
  logic [DATA_WIDTH:0]   fifo_q [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_q;
  logic [PW-1:0]         rd_ptr_q;
  logic [CW-1:0]         count_q;
  logic [CW-1:0]         count_d;
  logic                  push;
  logic                  pop;
  logic                  room;
  logic [ADDR_WIDTH-1:0] step;
  logic [ADDR_WIDTH-1:0] start_step;

`ifdef FOUR_MEM_RD_STRIDE_EN
  logic [ADDR_WIDTH-1:0] stride_q;
  assign step       = stride_q;
  assign start_step = stride_i;
`else
  assign step       = ADDR_WIDTH'(1);
  assign start_step = ADDR_WIDTH'(1);
`endif

  assign sys_wen_o = 1'b1;
  assign m_valid_o = (count_q != '0);
  assign m_data_o  = fifo_q[rd_ptr_q][DATA_WIDTH-1:0];
  assign m_last_o  = fifo_q[rd_ptr_q][DATA_WIDTH] & m_valid_o;

  assign push    = inflight_q;
  assign pop     = m_valid_o & m_ready_i;
  assign count_d = count_q + CW'(push) - CW'(pop);
  // A new issue is allowed only if every word already committed still fits after it lands.
  assign room    = (count_d + CW'(sys_cen_sel_o)) < CW'(FIFO_DEPTH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= S_IDLE;
      addr_q          <= '0;
      rem_q           <= '0;
      sys_last_q      <= 1'b0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      sys_addr_o      <= '0;
      sys_cen_sel_o   <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) fifo_q[i] <= '0;
`ifdef FOUR_MEM_RD_STRIDE_EN
      stride_q        <= '0;
`endif
    end else if (abort_i) begin
      state_q         <= S_IDLE;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      busy_o          <= 1'b0;
      done_o          <= 1'b0;
      sys_cen_sel_o   <= 1'b0;
    end else begin
      inflight_q      <= sys_cen_sel_o;
      inflight_last_q <= sys_last_q;
      count_q         <= count_d;
      sys_cen_sel_o   <= 1'b0;
      done_o          <= 1'b0;
      if (push) begin
        fifo_q[wr_ptr_q] <= {inflight_last_q, mem_rdata_i};
        wr_ptr_q         <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);

      case (state_q)
        S_IDLE: begin
          if (start_i) begin
            if (len_i == '0) begin
              done_o <= 1'b1;
            end else begin
              busy_o        <= 1'b1;
              sys_cen_sel_o <= 1'b1;
              sys_addr_o    <= base_addr_i;
              addr_q        <= base_addr_i + start_step;
              rem_q         <= len_i - (ADDR_WIDTH + 1)'(1);
              sys_last_q    <= (len_i == (ADDR_WIDTH + 1)'(1));
              state_q       <= (len_i == (ADDR_WIDTH + 1)'(1)) ? S_DRAIN : S_ISSUE;
`ifdef FOUR_MEM_RD_STRIDE_EN
              stride_q      <= stride_i;
`endif
            end
          end
        end
        S_ISSUE: begin
          if (room && rem_q != '0) begin
            sys_cen_sel_o <= 1'b1;
            sys_addr_o    <= addr_q;
            addr_q        <= addr_q + step;
            rem_q         <= rem_q - (ADDR_WIDTH + 1)'(1);
            sys_last_q    <= (rem_q == (ADDR_WIDTH + 1)'(1));
            if (rem_q == (ADDR_WIDTH + 1)'(1)) state_q <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          // Finished once the last read has landed and its beat has left the FIFO.
          if (!sys_cen_sel_o && !inflight_q && count_d == '0) begin
            done_o  <= 1'b1;
            busy_o  <= 1'b0;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_four_mem_result_reader.sv
// tb/tb_four_mem_result_reader.sv - self-checking bench for four_mem_result_reader
module tb_four_mem_result_reader;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [13:0] base = '0;
  logic [14:0] len = '0;
`ifdef FOUR_MEM_RD_STRIDE_EN
  logic [13:0] stride = 14'd1;
`endif
  logic        busy, done, cen, wen, m_valid, m_last;
  logic [13:0] sys_addr;
  logic [31:0] mem_rdata = 32'hDEADBEEF;
  logic [31:0] m_data;
  logic        m_ready = 1'b1;

  four_mem_result_reader #(.ADDR_WIDTH(14), .DATA_WIDTH(32), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .start_i(start), .abort_i(abort),
    .base_addr_i(base), .len_i(len),
`ifdef FOUR_MEM_RD_STRIDE_EN
    .stride_i(stride),
`endif
    .busy_o(busy), .done_o(done), .sys_addr_o(sys_addr), .sys_cen_sel_o(cen),
    .sys_wen_o(wen), .mem_rdata_i(mem_rdata), .m_data_o(m_data),
    .m_valid_o(m_valid), .m_ready_i(m_ready), .m_last_o(m_last)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: event occurred but none was expected", name);
  endtask

  function automatic logic [31:0] mem_word(input logic [13:0] a);
    return {6'd0, a[13:12], 8'h5A, 2'b00, a};
  endfunction

  // Bank memory: data appears the cycle after an issue, garbage otherwise.
  always @(posedge clk) mem_rdata <= cen ? mem_word(sys_addr) : 32'hDEADBEEF;

  int rdy_mode = 0;
  always @(posedge clk) begin
    #1;
    case (rdy_mode)
      0: m_ready = 1'b1;
      1: m_ready = ~m_ready;
      2: m_ready = ($urandom_range(0, 3) != 0);
      default: m_ready = $urandom_range(0, 1) != 0;
    endcase
  end

  // Reference model: expected issue addresses, expected beats, occupancy accounting.
  logic [13:0] addr_q[$];
  logic [32:0] beat_q[$];
  int          occ = 0;
  int          infl = 0;
  logic        busy_exp = 1'b0;
  logic        done_exp = 1'b0;
  logic        hold_pending = 1'b0;
  logic [31:0] hold_data;
  logic        hold_last;
  logic        mon_en = 1'b0;
  int          beats = 0;
  int          issues = 0;
  logic [13:0] last_issue = '0;
  logic [32:0] eb;
  logic        done_nxt;
  logic [13:0] a_m;
  logic [13:0] step_m;

  always @(negedge clk) begin
    if (mon_en) begin
      check("sys_wen", wen, 1'b1);
      check("m_valid", m_valid, occ != 0);
      check("busy", busy, busy_exp);
      check("done", done, done_exp);
      if (hold_pending) begin
        check("hold_data", m_data, hold_data);
        check("hold_last", m_last, hold_last);
      end
      if (cen) begin
        issues++;
        last_issue = sys_addr;
        check("issue_room", (occ + infl) < DEPTH, 1'b1);
        if (addr_q.size() == 0) flag("issue_unexpected");
        else check("issue_addr", sys_addr, addr_q.pop_front());
      end else if (addr_q.size() != 0 && busy_exp) begin
        check("issue_stall_full", occ + infl, DEPTH);
      end
      done_nxt = 1'b0;
      if (m_valid && m_ready) begin
        beats++;
        if (beat_q.size() == 0) flag("beat_unexpected");
        else begin
          eb = beat_q.pop_front();
          check("beat_data", m_data, eb[31:0]);
          check("beat_last", m_last, eb[32]);
          done_nxt = eb[32];
        end
      end
      if (abort) begin
        occ = 0; infl = 0; addr_q.delete(); beat_q.delete();
        busy_exp = 1'b0; done_exp = 1'b0; hold_pending = 1'b0;
      end else begin
        occ = occ + infl - (((occ != 0) && m_ready) ? 1 : 0);
        infl = cen ? 1 : 0;
        hold_pending = m_valid && !m_ready;
        hold_data = m_data;
        hold_last = m_last;
        done_exp = done_nxt;
        if (done_nxt) busy_exp = 1'b0;
        if (start && !busy_exp) begin
          if (len == 0) done_exp = 1'b1;
          else begin
            busy_exp = 1'b1;
`ifdef FOUR_MEM_RD_STRIDE_EN
            step_m = stride;
`else
            step_m = 14'd1;
`endif
            a_m = base;
            for (int i = 0; i < int'(len); i++) begin
              addr_q.push_back(a_m);
              beat_q.push_back({i == int'(len) - 1, mem_word(a_m)});
              a_m = a_m + step_m;
            end
          end
        end
      end
    end
  end

  task automatic wait_idle(input int bound);
    int c;
    c = 0;
    do begin
      @(posedge clk); #2;
      c++;
    end while (c < bound && (busy_exp || done_exp || addr_q.size() != 0 || beat_q.size() != 0 || c < 2));
    check("burst_timeout", c < bound, 1'b1);
  endtask

  task automatic run_burst(input logic [13:0] b, input logic [14:0] l);
    @(posedge clk); #1;
    base = b; len = l; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(4 * int'(l) + 50);
  endtask

  typedef struct {
    logic [13:0] base;
    logic [14:0] len;
    int          mode;
    int          exp_beats;
    logic [13:0] exp_last;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{14'h0000, 15'd8,     0, 8,     14'h0007};
    vecs[1] = '{14'h3FFE, 15'd4,     0, 4,     14'h0001};
    vecs[2] = '{14'h0010, 15'd16,    1, 16,    14'h001F};
    vecs[3] = '{14'h0000, 15'd0,     0, 0,     14'h0000};
    vecs[4] = '{14'h3FFF, 15'd1,     2, 1,     14'h3FFF};
    vecs[5] = '{14'h1234, 15'd5,     3, 5,     14'h1238};
    vecs[6] = '{14'h2000, 15'd16384, 0, 16384, 14'h1FFF};

    repeat (2) @(posedge clk);
    #3;
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_sys_addr", sys_addr, 14'h0);
    check("rst_cen", cen, 1'b0);
    check("rst_wen", wen, 1'b1);
    check("rst_m_valid", m_valid, 1'b0);
    check("rst_m_last", m_last, 1'b0);
    check("rst_m_data", m_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;

    for (int v = 0; v < 7; v++) begin
      rdy_mode = vecs[v].mode;
      beats = 0; issues = 0;
      run_burst(vecs[v].base, vecs[v].len);
      check("vec_beats", beats, vecs[v].exp_beats);
      check("vec_issues", issues, vecs[v].exp_beats);
      if (vecs[v].exp_beats != 0) check("vec_last_addr", last_issue, vecs[v].exp_last);
    end

    // Abort after the third beat, then a clean follow-up burst.
    rdy_mode = 0; beats = 0;
    @(posedge clk); #1;
    base = 14'h0000; len = 15'd10; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int c = 0; c < 100 && beats < 3; c++) @(posedge clk);
    check("abort_reach_beat3", beats >= 3, 1'b1);
    #1; abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    #3;
    check("abort_m_valid", m_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    repeat (3) @(posedge clk);
    beats = 0; issues = 0;
    run_burst(14'h0100, 15'd2);
    check("post_abort_beats", beats, 2);
    check("post_abort_last", last_issue, 14'h0101);

    // Abort and start together in IDLE: nothing happens.
    issues = 0;
    @(posedge clk); #1;
    base = 14'h0200; len = 15'd3; start = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; abort = 1'b0;
    repeat (4) @(posedge clk);
    check("abort_start_issues", issues, 0);

    // Start while busy is ignored.
    rdy_mode = 3; issues = 0; beats = 0;
    @(posedge clk); #1;
    base = 14'h0500; len = 15'd12; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1; base = 14'h3000; len = 15'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    wait_idle(200);
    check("busy_start_issues", issues, 12);
    check("busy_start_beats", beats, 12);

`ifdef FOUR_MEM_RD_STRIDE_EN
    rdy_mode = 0; issues = 0; stride = 14'h1000;
    run_burst(14'h1000, 15'd4);
    check("stride_issues", issues, 4);
    check("stride_last", last_issue, 14'h0000);
    stride = 14'd1;
`endif

    // Randomized bursts against the reference model.
    for (int r = 0; r < 25; r++) begin
      rdy_mode = $urandom_range(0, 3);
      beats = 0;
      len = ($urandom_range(0, 7) == 0) ? 15'd0 : 15'($urandom_range(1, 40));
      run_burst(14'($urandom), len);
      check("rand_beats", beats, int'(len));
    end

    // Asynchronous reset mid-burst.
    rdy_mode = 2;
    @(posedge clk); #1;
    base = 14'h0700; len = 15'd20; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #3;
    mon_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_busy", busy, 1'b0);
    check("arst_cen", cen, 1'b0);
    check("arst_sys_addr", sys_addr, 14'h0);
    check("arst_m_valid", m_valid, 1'b0);
    check("arst_m_last", m_last, 1'b0);
    check("arst_m_data", m_data, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    occ = 0; infl = 0; addr_q.delete(); beat_q.delete();
    busy_exp = 1'b0; done_exp = 1'b0; hold_pending = 1'b0;
    mon_en = 1'b1;
    beats = 0;
    run_burst(14'h0042, 15'd3);
    check("post_arst_beats", beats, 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
